// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the LFSR family.
//   lfsr_mode_e      : Fibonacci (external XOR) or Galois (internal XOR) form
//   lfsr_default_fib : maximal-length Fibonacci tap mask for widths 3..8
//   lfsr_default_gal : maximal-length Galois toggle mask for widths 3..8
//   lfsr_step        : one-step next-state function for widths up to 32
package lfsr_pkg;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // Fibonacci masks: bit i set means s[i] joins the feedback XOR.
  // Widths outside 3..8 return zero, so the caller must supply taps.
  function automatic logic [31:0] lfsr_default_fib(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Galois masks are the reciprocal polynomials; bit 0 is always set
  // so the bit shifted out of the MSB re-enters at the bottom.
  function automatic logic [31:0] lfsr_default_gal(input int width);
    case (width)
      3:       return 32'h0000_0003;
      4:       return 32'h0000_0003;
      5:       return 32'h0000_0005;
      6:       return 32'h0000_0003;
      7:       return 32'h0000_0003;
      8:       return 32'h0000_001D;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Advance a state held in the low 'width' bits of a 32-bit word.
  // Bits at and above 'width' in the result are always zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                            input lfsr_mode_e mode,
                                            input logic [31:0] fib_taps,
                                            input logic [31:0] gal_taps,
                                            input int width);
    logic [31:0] mask;
    logic [31:0] shifted;
    logic        msb;
    logic        fb;
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    msb     = |(state & (32'd1 << (width - 1)));
    shifted = (state << 1) & mask;
    if (mode == LFSR_FIB) begin
      fb = ^(state & fib_taps & mask);
      return shifted | {31'd0, fb};
    end
    return shifted ^ (msb ? (gal_taps & mask) : 32'd0);
  endfunction

endpackage

// File: rtl/lfsr_if.sv
// lfsr_if: control and observation bundle of one LFSR generator.
//   master (controller): drives en, load, seed_in, mode; observes results
//   slave  (lfsr_gen)  : drives q, serial_out, lockup, period_done, period_len
interface lfsr_if #(
  parameter int WIDTH = 5
) ();
  import lfsr_pkg::*;

  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  lfsr_mode_e       mode;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             lockup;
  logic             period_done;
  logic [WIDTH-1:0] period_len;

  modport master (
    output en, load, seed_in, mode,
    input  q, serial_out, lockup, period_done, period_len
  );

  modport slave (
    input  en, load, seed_in, mode,
    output q, serial_out, lockup, period_done, period_len
  );

endinterface

// File: rtl/lfsr_next.sv
// lfsr_next: purely combinational next-state for both LFSR forms.
// Kept separate so a parallel multi-step scrambler can chain copies.
//   state : current register value
//   mode  : LFSR_FIB or LFSR_GAL
//   next  : value after exactly one step
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(lfsr_default_fib(WIDTH)),
  parameter logic [WIDTH-1:0] GAL_TAPS = WIDTH'(lfsr_default_gal(WIDTH))
) (
  input  logic [WIDTH-1:0] state,
  input  lfsr_mode_e       mode,
  output logic [WIDTH-1:0] next
);

  logic [31:0] next_full;
  logic        unused_upper;

  // The shared helper works on a 32-bit word; the upper bits come back
  // zero and are folded into a dummy so only the low WIDTH bits matter.
  assign next_full    = lfsr_step(32'(state), mode, 32'(FIB_TAPS),
                                  32'(GAL_TAPS), WIDTH);
  assign next         = next_full[WIDTH-1:0];
  assign unused_upper = ^next_full;

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised LFSR with Fibonacci/Galois form, seed load,
// step enable, all-zero lockup flag and period measurement.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : lfsr_if.slave
//          en/load/seed_in/mode in; q, serial_out, lockup,
//          period_done, period_len out
// Build option: define LFSR_LOCKUP_RECOVER_EN to replace any zero load
// with SEED and to make a step out of the zero state land on SEED.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 5,
  parameter logic [WIDTH-1:0] FIB_TAPS = WIDTH'(lfsr_default_fib(WIDTH)),
  parameter logic [WIDTH-1:0] GAL_TAPS = WIDTH'(lfsr_default_gal(WIDTH)),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1)
) (
  input logic   clk,
  input logic   rst,
  lfsr_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] seed_ref;
  logic [WIDTH-1:0] step_cnt;
  logic             period_done_r;
  logic [WIDTH-1:0] period_len_r;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;

  lfsr_next #(
    .WIDTH    (WIDTH),
    .FIB_TAPS (FIB_TAPS),
    .GAL_TAPS (GAL_TAPS)
  ) u_next (
    .state (q_r),
    .mode  (bus.mode),
    .next  (next_q)
  );

  // Values written on a load or a step. With recovery enabled the zero
  // state can never be entered by a load and is left on the first step.
  always_comb begin
    load_val = bus.seed_in;
    step_val = next_q;
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (bus.seed_in == '0) begin
      load_val = SEED;
    end
    if (q_r == '0) begin
      step_val = SEED;
    end
`endif
  end

  // State, reference seed and period counter. A load re-arms the period
  // measurement against the new seed; a step that lands back on the
  // reference records the length and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r           <= SEED;
      seed_ref      <= SEED;
      step_cnt      <= '0;
      period_done_r <= 1'b0;
      period_len_r  <= '0;
    end else if (bus.load) begin
      q_r           <= load_val;
      seed_ref      <= load_val;
      step_cnt      <= '0;
      period_done_r <= 1'b0;
    end else if (bus.en) begin
      q_r <= step_val;
      if (step_val == seed_ref) begin
        period_done_r <= 1'b1;
        period_len_r  <= step_cnt + 1'b1;
        step_cnt      <= '0;
      end else begin
        period_done_r <= 1'b0;
        step_cnt      <= step_cnt + 1'b1;
      end
    end else begin
      period_done_r <= 1'b0;
    end
  end

  assign bus.q           = q_r;
  assign bus.serial_out  = q_r[WIDTH-1];
  assign bus.lockup      = (q_r == '0);
  assign bus.period_done = period_done_r;
  assign bus.period_len  = period_len_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: self-checking bench for lfsr_gen at the default 5-bit
// configuration. A behavioural model pushes the expected outputs of each
// cycle to a queue as stimulus is driven; each test pops and compares
// them against the DUT snapshot taken 1 time unit after the clock edge.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  typedef struct packed {
    logic [4:0] q;
    logic       ser;
    logic       lock;
    logic       done;
    logic [4:0] plen;
  } snap_t;

  logic clk;
  logic rst;

  lfsr_if #(.WIDTH(5)) bus ();

  lfsr_gen #(.WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  snap_t expQ[$];
  snap_t obsQ[$];

  int checkCount = 0;
  int passCount  = 0;

  logic [4:0] mq;
  logic [4:0] mref;
  logic [4:0] mcnt;
  logic [4:0] mlen;
  logic       mdone;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural reference of one clock cycle, written from the tap
  // definitions bit by bit.
  task automatic model_reset();
    mq    = 5'b00001;
    mref  = 5'b00001;
    mcnt  = 5'd0;
    mlen  = 5'd0;
    mdone = 1'b0;
  endtask

  task automatic model_update(input logic e, input logic l,
                              input logic [4:0] s, input logic m);
    logic [4:0] fibTaps;
    logic [4:0] galTaps;
    logic [4:0] nxt;
    logic       fb;
    fibTaps = 5'h14;
    galTaps = 5'h05;
    if (l) begin
      nxt = s;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (nxt == 5'd0) nxt = 5'b00001;
`endif
      mq    = nxt;
      mref  = nxt;
      mcnt  = 5'd0;
      mdone = 1'b0;
    end else if (e) begin
      if (m == 1'b0) begin
        fb = 1'b0;
        for (int i = 0; i < 5; i++) begin
          if (fibTaps[i]) fb = fb ^ mq[i];
        end
        nxt = {mq[3:0], fb};
      end else begin
        nxt = {mq[3:0], 1'b0};
        if (mq[4]) nxt = nxt ^ galTaps;
      end
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (mq == 5'd0) nxt = 5'b00001;
`endif
      mq = nxt;
      if (nxt == mref) begin
        mdone = 1'b1;
        mlen  = mcnt + 5'd1;
        mcnt  = 5'd0;
      end else begin
        mdone = 1'b0;
        mcnt  = mcnt + 5'd1;
      end
    end else begin
      mdone = 1'b0;
    end
  endtask

  // Drive one cycle: set inputs, record the expectation, clock, snapshot.
  task automatic drive_cycle(input logic e, input logic l,
                             input logic [4:0] s, input logic m);
    snap_t x;
    bus.en      = e;
    bus.load    = l;
    bus.seed_in = s;
    bus.mode    = lfsr_mode_e'(m);
    model_update(e, l, s, m);
    x.q    = mq;
    x.ser  = mq[4];
    x.lock = (mq == 5'd0);
    x.done = mdone;
    x.plen = mlen;
    expQ.push_back(x);
    @(posedge clk);
    #1;
    obsQ.push_back({bus.q, bus.serial_out, bus.lockup, bus.period_done,
                    bus.period_len});
  endtask

  task automatic test_reset();
    snap_t e;
    snap_t o;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.seed_in = 5'd0;
    bus.mode    = LFSR_FIB;
    repeat (2) @(posedge clk);
    #1;
    checkCount++;
    if (bus.q === 5'b00001 && bus.lockup === 1'b0 &&
        bus.period_done === 1'b0 && bus.period_len === 5'd0)
      passCount++;
    else
      $display("[TB] FAIL reset_values: got q=%b lock=%b done=%b len=%0d, expected q=00001 lock=0 done=0 len=0",
               bus.q, bus.lockup, bus.period_done, bus.period_len);
    rst = 1'b0;
    model_reset();
    repeat (3) drive_cycle(1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e && o.q === 5'b00001 && o.lock === 1'b0 && o.done === 1'b0)
        passCount++;
      else
        $display("[TB] FAIL reset_hold%0d: got {q,ser,lock,done,len}=%b, expected %b", i, o, e);
    end
  endtask

  task automatic test_fibonacci();
    snap_t e;
    snap_t o;
    logic [4:0] fibSeq[5];
    fibSeq = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    repeat (31) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e) passCount++;
      else $display("[TB] FAIL fib_step%0d: got {q,ser,lock,done,len}=%b, expected %b", i, o, e);
      if (i < 5) begin
        checkCount++;
        if (o.q === fibSeq[i]) passCount++;
        else $display("[TB] FAIL fib_seq%0d: got q=%b, expected %b", i, o.q, fibSeq[i]);
      end
      if (i == 30) begin
        checkCount++;
        if (o.q === 5'b00001 && o.done === 1'b1 && o.plen === 5'd31) passCount++;
        else $display("[TB] FAIL fib_period: got q=%b done=%b len=%0d, expected q=00001 done=1 len=31",
                      o.q, o.done, o.plen);
      end
    end
  endtask

  task automatic test_galois();
    snap_t e;
    snap_t o;
    logic [4:0] galSeq[5];
    galSeq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00101};
    repeat (31) drive_cycle(1'b1, 1'b0, 5'd0, 1'b1);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e) passCount++;
      else $display("[TB] FAIL gal_step%0d: got {q,ser,lock,done,len}=%b, expected %b", i, o, e);
      if (i < 5) begin
        checkCount++;
        if (o.q === galSeq[i]) passCount++;
        else $display("[TB] FAIL gal_seq%0d: got q=%b, expected %b", i, o.q, galSeq[i]);
      end
      if (i == 30) begin
        checkCount++;
        if (o.q === 5'b00001 && o.done === 1'b1 && o.plen === 5'd31) passCount++;
        else $display("[TB] FAIL gal_period: got q=%b done=%b len=%0d, expected q=00001 done=1 len=31",
                      o.q, o.done, o.plen);
      end
    end
  endtask

  // Load with en also high: no step in the load cycle, and the period
  // count restarts so the seed comes back after exactly 31 steps.
  task automatic test_load();
    snap_t e;
    snap_t o;
    repeat (3) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0);
    drive_cycle(1'b1, 1'b1, 5'b10110, 1'b0);
    repeat (31) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e) passCount++;
      else $display("[TB] FAIL load_step%0d: got {q,ser,lock,done,len}=%b, expected %b", i, o, e);
      if (i == 3) begin
        checkCount++;
        if (o.q === 5'b10110 && o.done === 1'b0) passCount++;
        else $display("[TB] FAIL load_value: got q=%b done=%b, expected q=10110 done=0", o.q, o.done);
      end
      if (i == 34) begin
        checkCount++;
        if (o.q === 5'b10110 && o.done === 1'b1 && o.plen === 5'd31) passCount++;
        else $display("[TB] FAIL load_period: got q=%b done=%b len=%0d, expected q=10110 done=1 len=31",
                      o.q, o.done, o.plen);
      end
    end
  endtask

  // Random enable and mode changes; the count carries across mode switches.
  task automatic test_mode_switch();
    snap_t e;
    snap_t o;
    for (int n = 0; n < 40; n++)
      drive_cycle(1'($urandom_range(0, 1)), 1'b0, 5'd0, 1'($urandom_range(0, 1)));
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e) passCount++;
      else $display("[TB] FAIL mode_mix%0d: got {q,ser,lock,done,len}=%b, expected %b", i, o, e);
    end
  endtask

  task automatic test_lockup_zero();
    snap_t e;
    snap_t o;
    drive_cycle(1'b0, 1'b1, 5'd0, 1'b0);
    repeat (4) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e) passCount++;
      else $display("[TB] FAIL zero_step%0d: got {q,ser,lock,done,len}=%b, expected %b", i, o, e);
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (i == 0) begin
        checkCount++;
        if (o.q === 5'b00001 && o.lock === 1'b0) passCount++;
        else $display("[TB] FAIL zero_recover: got q=%b lock=%b, expected q=00001 lock=0", o.q, o.lock);
      end
`else
      checkCount++;
      if (o.q === 5'd0 && o.lock === 1'b1 && (i == 0 || o.done === 1'b1)) passCount++;
      else $display("[TB] FAIL zero_sticky%0d: got q=%b lock=%b done=%b, expected q=00000 lock=1",
                    i, o.q, o.lock, o.done);
`endif
    end
  endtask

  task automatic test_async_reset();
    snap_t e;
    snap_t o;
    logic [4:0] fibSeq[5];
    fibSeq = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    drive_cycle(1'b0, 1'b1, 5'b01101, 1'b0);
    repeat (3) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e) passCount++;
      else $display("[TB] FAIL pre_reset: got {q,ser,lock,done,len}=%b, expected %b", o, e);
    end
    #2;
    rst = 1'b1;
    #1;
    checkCount++;
    if (bus.q === 5'b00001 && bus.period_len === 5'd0 && bus.period_done === 1'b0 &&
        bus.lockup === 1'b0)
      passCount++;
    else
      $display("[TB] FAIL async_reset: got q=%b len=%0d done=%b lock=%b, expected q=00001 len=0 done=0 lock=0",
               bus.q, bus.period_len, bus.period_done, bus.lockup);
    @(posedge clk);
    #1;
    checkCount++;
    if (bus.q === 5'b00001) passCount++;
    else $display("[TB] FAIL reset_held: got q=%b, expected 00001", bus.q);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (5) drive_cycle(1'b1, 1'b0, 5'd0, 1'b0);
    for (int i = 0; expQ.size() > 0; i++) begin
      e = expQ.pop_front();
      o = obsQ.pop_front();
      checkCount++;
      if (o === e && o.q === fibSeq[i]) passCount++;
      else $display("[TB] FAIL resume%0d: got {q,ser,lock,done,len}=%b, expected %b (q=%b)",
                    i, o, e, fibSeq[i]);
    end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_galois();
    test_load();
    test_mode_switch();
    test_lockup_zero();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got %0d/%0d checks", passCount, checkCount);
    $fatal(1, "[TB] timeout");
  end

endmodule
